// File: rtl/memory_access_unit.sv
// Memory access unit: MAR/MDR pair with a four-state request sequencer that
// drives ROM/RAM strobes and the shared tri-state data bus.
module memory_access_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] abus,
  input  logic        mar_loadn,
  input  logic        rdn,
  input  logic        wrn,
  input  logic        outn,
  inout  wire  [7:0]  dbus,
  output logic        ready,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  mem_wdata,
  output logic        mem_oe,
  output logic        mem_we
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]  state_r;
  logic [1:0]  state_next_s;
  logic [15:0] mar_r;
  logic [7:0]  mdr_r;
  logic        arm_r;
  logic        op_write_r;
  logic        wait_cnt_r;
  logic        oe_r;
  logic        we_r;
  logic        ready_r;
  logic        rd_req_s;
  logic        wr_req_s;
  logic        accept_s;
  logic        last_phase_s;
  logic        wr_next_s;
  logic        busy_next_s;

  assign rd_req_s    = ~rdn & wrn;
  assign wr_req_s    = rdn & ~wrn;
  assign accept_s    = (state_r == ST_IDLE) & arm_r & (rd_req_s | wr_req_s);
  assign wr_next_s   = accept_s ? wr_req_s : op_write_r;
  assign busy_next_s = (state_next_s == ST_ACCESS) | (state_next_s == ST_WAIT);

  // Next-state decode; last_phase_s marks the cycle whose closing edge ends the strobe window.
  always_comb begin
    state_next_s = state_r;
    last_phase_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_next_s = ST_ACCESS;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (mar_r[15]) begin
          state_next_s = ST_DONE;
          last_phase_s = 1'b1;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_r) begin
          state_next_s = ST_DONE;
          last_phase_s = 1'b1;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Sequencer state, MAR/MDR datapath and registered strobes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r    <= ST_IDLE;
      mar_r      <= 16'h0000;
      mdr_r      <= 8'h00;
      arm_r      <= 1'b1;
      op_write_r <= 1'b0;
      wait_cnt_r <= 1'b0;
      oe_r       <= 1'b0;
      we_r       <= 1'b0;
      ready_r    <= 1'b1;
    end else begin
      state_r <= state_next_s;
      if ((state_r == ST_IDLE) && !mar_loadn) begin
        mar_r <= abus;
      end
      if (accept_s) begin
        op_write_r <= wr_req_s;
      end
      // A request must be seen released while idle before another is taken.
      if (accept_s) begin
        arm_r <= 1'b0;
      end else if ((state_r == ST_IDLE) && rdn && wrn) begin
        arm_r <= 1'b1;
      end
      if (state_r == ST_WAIT) begin
        wait_cnt_r <= ~wait_cnt_r;
      end else begin
        wait_cnt_r <= 1'b0;
      end
      if (accept_s && wr_req_s) begin
        mdr_r <= dbus;
      end else if (last_phase_s && !op_write_r) begin
        mdr_r <= mem_rdata;
      end
      // ROM writes run the same timing but never strobe the memory.
      oe_r    <= busy_next_s & ~wr_next_s;
      we_r    <= busy_next_s & wr_next_s & mar_r[15];
      ready_r <= (state_next_s == ST_IDLE);
    end
  end

  assign dbus      = (!outn && wrn) ? mdr_r : {8{1'bz}};
  assign mem_addr  = mar_r;
  assign mem_wdata = mdr_r;
  assign mem_oe    = oe_r;
  assign mem_we    = we_r;
  assign ready     = ready_r;

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed self-checking bench for memory_access_unit.
module tb_memory_access_unit;

  logic        clk;
  logic        resetn;
  logic [15:0] abus;
  logic        mar_loadn;
  logic        rdn;
  logic        wrn;
  logic        outn;
  wire  [7:0]  dbus;
  logic        ready;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic [7:0]  mem_wdata;
  logic        mem_oe;
  logic        mem_we;

  logic [7:0]  tb_dbus;
  logic        tb_dbus_en;
  int          checks;
  int          errors;

  assign dbus = tb_dbus_en ? tb_dbus : {8{1'bz}};

  memory_access_unit dut (
    .clk       (clk),
    .resetn    (resetn),
    .abus      (abus),
    .mar_loadn (mar_loadn),
    .rdn       (rdn),
    .wrn       (wrn),
    .outn      (outn),
    .dbus      (dbus),
    .ready     (ready),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_wdata (mem_wdata),
    .mem_oe    (mem_oe),
    .mem_we    (mem_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mar(input logic [15:0] a);
    abus      = a;
    mar_loadn = 1'b0;
    tick();
    mar_loadn = 1'b1;
  endtask

  // Runs n cycles, dropping rdn/wrn and the bench data driver after 'hold' edges.
  task automatic run(input int n, input int hold,
                     output int oe_n, output int we_n, output int busy_n, output int both_n);
    oe_n = 0; we_n = 0; busy_n = 0; both_n = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (i + 1 == hold) begin
        rdn = 1'b1; wrn = 1'b1; tb_dbus_en = 1'b0;
      end
      if (mem_oe === 1'b1) oe_n++;
      if (mem_we === 1'b1) we_n++;
      if (ready !== 1'b1) busy_n++;
      if (mem_oe === 1'b1 && mem_we === 1'b1) both_n++;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b1; abus = 16'h0000; mar_loadn = 1'b1; rdn = 1'b1; wrn = 1'b1;
    outn = 1'b1; mem_rdata = 8'h00; tb_dbus = 8'h00; tb_dbus_en = 1'b0;
    #1 resetn = 1'b0;
    #2;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
    checks++; if (mem_oe !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_strobes got oe=%b we=%b want 0 0", mem_oe, mem_we); end
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_mar got %h want 0000", mem_addr); end
    checks++; if (mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_mdr got %h want 00", mem_wdata); end
    @(negedge clk);
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_ram_write();
    int oe_n, we_n, busy_n, both_n;
    load_mar(16'h8001);
    checks++; if (mem_addr !== 16'h8001) begin errors++; $display("FAIL ramwr_addr got %h want 8001", mem_addr); end
    tb_dbus = 8'hA5; tb_dbus_en = 1'b1; wrn = 1'b0;
    run(8, 1, oe_n, we_n, busy_n, both_n);
    checks++; if (we_n !== 1) begin errors++; $display("FAIL ramwr_we_cycles got %0d want 1", we_n); end
    checks++; if (busy_n !== 2) begin errors++; $display("FAIL ramwr_busy got %0d want 2", busy_n); end
    checks++; if (oe_n !== 0 || both_n !== 0) begin errors++; $display("FAIL ramwr_oe got %0d/%0d want 0/0", oe_n, both_n); end
    checks++; if (mem_wdata !== 8'hA5) begin errors++; $display("FAIL ramwr_mdr got %h want a5", mem_wdata); end
  endtask

  task automatic test_rom_read();
    int oe_n, we_n, busy_n, both_n;
    load_mar(16'h1234);
    mem_rdata = 8'h3C; rdn = 1'b0;
    run(8, 1, oe_n, we_n, busy_n, both_n);
    checks++; if (oe_n !== 3) begin errors++; $display("FAIL romrd_oe_cycles got %0d want 3", oe_n); end
    checks++; if (busy_n !== 4) begin errors++; $display("FAIL romrd_busy got %0d want 4", busy_n); end
    checks++; if (we_n !== 0 || both_n !== 0) begin errors++; $display("FAIL romrd_we got %0d/%0d want 0/0", we_n, both_n); end
    outn = 1'b0;
    #1;
    checks++; if (dbus !== 8'h3C) begin errors++; $display("FAIL romrd_dbus got %h want 3c", dbus); end
    outn = 1'b1;
  endtask

  task automatic test_rom_write();
    int oe_n, we_n, busy_n, both_n;
    load_mar(16'h0010);
    tb_dbus = 8'h77; tb_dbus_en = 1'b1; wrn = 1'b0;
    run(8, 1, oe_n, we_n, busy_n, both_n);
    checks++; if (we_n !== 0 || oe_n !== 0) begin errors++; $display("FAIL romwr_strobes got we=%0d oe=%0d want 0 0", we_n, oe_n); end
    checks++; if (busy_n !== 4) begin errors++; $display("FAIL romwr_busy got %0d want 4", busy_n); end
    checks++; if (mem_wdata !== 8'h77) begin errors++; $display("FAIL romwr_mdr got %h want 77", mem_wdata); end
  endtask

  task automatic test_ignored_inputs();
    int oe_n, we_n, busy_n, both_n;
    rdn = 1'b0; wrn = 1'b0; outn = 1'b0; tb_dbus = 8'h00; tb_dbus_en = 1'b1;
    #1;
    checks++; if (dbus !== 8'h00) begin errors++; $display("FAIL ign_dbus_wrn got %h want 00", dbus); end
    run(4, 4, oe_n, we_n, busy_n, both_n);
    checks++; if (oe_n !== 0 || we_n !== 0 || busy_n !== 0) begin errors++; $display("FAIL ign_both_low got oe=%0d we=%0d busy=%0d want 0 0 0", oe_n, we_n, busy_n); end
    outn = 1'b1; tb_dbus = 8'h00; tb_dbus_en = 1'b1;
    #1;
    checks++; if (dbus !== 8'h00) begin errors++; $display("FAIL ign_dbus_outn got %h want 00", dbus); end
    tb_dbus_en = 1'b0;
  endtask

  task automatic test_held_request();
    int oe_n, we_n, busy_n, both_n;
    load_mar(16'h8040);
    mem_rdata = 8'h11; rdn = 1'b0;
    run(10, 10, oe_n, we_n, busy_n, both_n);
    checks++; if (oe_n !== 1 || busy_n !== 2) begin errors++; $display("FAIL held_one_burst got oe=%0d busy=%0d want 1 2", oe_n, busy_n); end
    tick();
    mem_rdata = 8'h22; rdn = 1'b0;
    run(6, 1, oe_n, we_n, busy_n, both_n);
    checks++; if (oe_n !== 1 || busy_n !== 2) begin errors++; $display("FAIL held_second_burst got oe=%0d busy=%0d want 1 2", oe_n, busy_n); end
    checks++; if (mem_wdata !== 8'h22) begin errors++; $display("FAIL held_mdr got %h want 22", mem_wdata); end
  endtask

  task automatic test_busy_mar();
    load_mar(16'h1234);
    mem_rdata = 8'h44; rdn = 1'b0;
    tick();
    rdn = 1'b1; abus = 16'hFFFF; mar_loadn = 1'b0;
    repeat (4) tick();
    mar_loadn = 1'b1;
    checks++; if (mem_addr !== 16'h1234) begin errors++; $display("FAIL busy_mar got %h want 1234", mem_addr); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL busy_mar_ready got %b want 1", ready); end
    tick();
  endtask

  task automatic test_reset_midop();
    int oe_n, we_n, busy_n, both_n;
    load_mar(16'h1234);
    mem_rdata = 8'h66; rdn = 1'b0;
    tick();
    rdn = 1'b1;
    tick();
    checks++; if (mem_oe !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL midop_pre got oe=%b ready=%b want 1 0", mem_oe, ready); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (mem_oe !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL midop_strobes got oe=%b we=%b want 0 0", mem_oe, mem_we); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL midop_ready got %b want 1", ready); end
    checks++; if (mem_addr !== 16'h0000 || mem_wdata !== 8'h00) begin errors++; $display("FAIL midop_regs got mar=%h mdr=%h want 0000 00", mem_addr, mem_wdata); end
    rdn = 1'b0; mar_loadn = 1'b0; abus = 16'h9999;
    repeat (3) tick();
    mar_loadn = 1'b1;
    checks++; if (ready !== 1'b1 || mem_oe !== 1'b0 || mem_addr !== 16'h0000) begin errors++; $display("FAIL midop_hold got ready=%b oe=%b mar=%h want 1 0 0000", ready, mem_oe, mem_addr); end
    mem_rdata = 8'h5A;
    @(negedge clk);
    resetn = 1'b1;
    run(8, 1, oe_n, we_n, busy_n, both_n);
    checks++; if (oe_n !== 3 || busy_n !== 4) begin errors++; $display("FAIL midop_after got oe=%0d busy=%0d want 3 4", oe_n, busy_n); end
    checks++; if (mem_wdata !== 8'h5A) begin errors++; $display("FAIL midop_after_mdr got %h want 5a", mem_wdata); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_ram_write();
    test_rom_read();
    test_rom_write();
    test_ignored_inputs();
    test_held_request();
    test_busy_mar();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
